// File: rtl/seq_trigger_pkg.sv
// -----------------------------------------------------------------------------
// seq_trigger_pkg
// Shared types and default constants for the sequence trigger monitor:
//   - trig_state_e      : sequencer state (SEARCH / FIRED)
//   - AES_PAT0..3       : default 128-bit trigger words (stage 0 first)
//   - DEFAULT_PATTERNS  : the four default words packed, stage 0 in the MSBs
//   - DEFAULT_ROT_INIT  : default 128-bit rotator reload value (0xaaaa...)
// -----------------------------------------------------------------------------
package seq_trigger_pkg;

  typedef enum logic [0:0] {
    SEARCH = 1'b0,
    FIRED  = 1'b1
  } trig_state_e;

  localparam logic [127:0] AES_PAT0 = 128'h3243f6a8_885a308d_313198a2_e0370734;
  localparam logic [127:0] AES_PAT1 = 128'h00112233_44556677_8899aabb_ccddeeff;
  localparam logic [127:0] AES_PAT2 = 128'h0;
  localparam logic [127:0] AES_PAT3 = 128'h1;

  localparam logic [511:0] DEFAULT_PATTERNS = {AES_PAT0, AES_PAT1, AES_PAT2, AES_PAT3};

  localparam logic [127:0] DEFAULT_ROT_INIT = {64{2'b10}};

endpackage

// File: rtl/seq_trigger_monitor_rotator.sv
// -----------------------------------------------------------------------------
// trig_activity_rotator
// Rotating activity register used to generate switching activity after a
// trigger. Rotates right by one bit on every enabled cycle; reload has
// priority over rotation.
// Ports:
//   clk    : clock, rising edge
//   rst    : asynchronous active-high reset (loads ROT_INIT)
//   reload : synchronous reload to ROT_INIT
//   en     : rotate right by one this cycle
//   q      : register contents
// -----------------------------------------------------------------------------
module trig_activity_rotator
  import seq_trigger_pkg::*;
#(
  parameter int               ROT_W    = 128,
  parameter logic [ROT_W-1:0] ROT_INIT = {ROT_W/2{2'b10}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             reload,
  input  logic             en,
  output logic [ROT_W-1:0] q
);

  // Rotator register: reset/reload to ROT_INIT, otherwise rotate right when enabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= ROT_INIT;
    end else if (reload) begin
      q <= ROT_INIT;
    end else if (en) begin
      q <= {q[0], q[ROT_W-1:1]};
    end else begin
      q <= q;
    end
  end

endmodule

// File: rtl/seq_trigger_monitor.sv
// -----------------------------------------------------------------------------
// seq_trigger_monitor
// Watches a wide data bus for an ordered sequence of NUM_STAGES programmed
// words. Completing the sequence raises trig (sticky or pulsed), bumps a
// saturating fire counter and lets the activity rotator run while trig is high.
// Ports:
//   clk        : clock, rising edge
//   rst        : asynchronous active-high reset
//   arm        : enables matching; low holds the sequencer at stage 0
//   clear      : synchronous re-arm (drops trig, stage 0, reloads rotator)
//   data_valid : qualifies data
//   data       : monitored bus
//   trig       : registered trigger
//   stage      : number of stages matched so far
//   rot_reg    : activity rotator contents
//   fire_count : saturating count of fire events
// -----------------------------------------------------------------------------
module seq_trigger_monitor
  import seq_trigger_pkg::*;
#(
  parameter int                          DATA_W            = 128,
  parameter int                          NUM_STAGES        = 4,
  parameter logic [NUM_STAGES*DATA_W-1:0] PATTERNS         = DEFAULT_PATTERNS,
  parameter bit                          RESET_ON_MISMATCH = 1'b0,
  parameter int                          WINDOW            = 0,
  parameter bit                          STICKY            = 1'b1,
  parameter int                          PULSE_LEN         = 8,
  parameter int                          ROT_W             = 128,
  parameter logic [ROT_W-1:0]            ROT_INIT          = {ROT_W/2{2'b10}}
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              arm,
  input  logic                              clear,
  input  logic                              data_valid,
  input  logic [DATA_W-1:0]                 data,
  output logic                              trig,
  output logic [$clog2(NUM_STAGES+1)-1:0]   stage,
  output logic [ROT_W-1:0]                  rot_reg,
  output logic [15:0]                       fire_count
);

  localparam int SW    = $clog2(NUM_STAGES + 1);
  localparam int WIN_W = (WINDOW > 0) ? $clog2(WINDOW + 1) : 1;
  localparam int PW    = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;

  trig_state_e      state_r, state_s;
  logic [SW-1:0]    stage_r, stage_s;
  logic             trig_r, trig_s;
  logic [15:0]      fc_r, fc_s;
  logic [WIN_W-1:0] win_cnt_r, win_cnt_s;
  logic [PW-1:0]    pulse_cnt_r, pulse_cnt_s;
  logic             rot_reload_s;
  logic             match_s;
  logic             head_match_s;
  logic             last_stage_s;
  logic             timeout_s;

  // Word expected at a given stage; stage 0 lives in the MSBs of PATTERNS.
  function automatic logic [DATA_W-1:0] pattern_at(input logic [SW-1:0] idx);
    logic [DATA_W-1:0] p;
    p = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      p = (idx == SW'(i)) ? PATTERNS[(NUM_STAGES-1-i)*DATA_W +: DATA_W] : p;
    end
    return p;
  endfunction

  // Match qualifiers for the current cycle.
  always_comb begin
    match_s      = data_valid && (data == pattern_at(stage_r));
    head_match_s = (data == PATTERNS[(NUM_STAGES-1)*DATA_W +: DATA_W]);
    last_stage_s = (stage_r == SW'(NUM_STAGES - 1));
    // Window expires on the WINDOW-th cycle without an advance.
    timeout_s    = (WINDOW > 0) && (stage_r != {SW{1'b0}}) &&
                   (win_cnt_r == WIN_W'(WINDOW - 1));
  end

  // Next-state logic: clear, then !arm, then FIRED handling, then timeout/match.
  always_comb begin
    state_s      = state_r;
    stage_s      = stage_r;
    trig_s       = trig_r;
    fc_s         = fc_r;
    win_cnt_s    = win_cnt_r;
    pulse_cnt_s  = pulse_cnt_r;
    rot_reload_s = 1'b0;
    if (clear) begin
      state_s      = SEARCH;
      stage_s      = {SW{1'b0}};
      trig_s       = 1'b0;
      win_cnt_s    = {WIN_W{1'b0}};
      pulse_cnt_s  = {PW{1'b0}};
      rot_reload_s = 1'b1;
    end else if (!arm && (state_r == SEARCH)) begin
      stage_s   = {SW{1'b0}};
      win_cnt_s = {WIN_W{1'b0}};
    end else begin
      case (state_r)
        FIRED: begin
          if (!STICKY) begin
            if (pulse_cnt_r == PW'(PULSE_LEN - 1)) begin
              trig_s      = 1'b0;
              stage_s     = {SW{1'b0}};
              state_s     = SEARCH;
              pulse_cnt_s = {PW{1'b0}};
            end else begin
              pulse_cnt_s = pulse_cnt_r + PW'(1);
            end
          end else begin
            trig_s = 1'b1;
          end
        end
        SEARCH: begin
          if (match_s) begin
            win_cnt_s = {WIN_W{1'b0}};
            if (last_stage_s) begin
              stage_s     = SW'(NUM_STAGES);
              state_s     = FIRED;
              trig_s      = 1'b1;
              pulse_cnt_s = {PW{1'b0}};
              fc_s        = (fc_r == 16'hFFFF) ? fc_r : fc_r + 16'd1;
            end else begin
              stage_s = stage_r + SW'(1);
            end
          end else if (timeout_s) begin
            stage_s   = {SW{1'b0}};
            win_cnt_s = {WIN_W{1'b0}};
          end else if (data_valid && RESET_ON_MISMATCH) begin
            // Mismatching word may itself start a fresh sequence.
            stage_s   = head_match_s ? SW'(1) : {SW{1'b0}};
            win_cnt_s = {WIN_W{1'b0}};
          end else if ((WINDOW > 0) && (stage_r != {SW{1'b0}})) begin
            win_cnt_s = win_cnt_r + WIN_W'(1);
          end else begin
            win_cnt_s = {WIN_W{1'b0}};
          end
        end
        default: begin
          state_s = SEARCH;
          stage_s = {SW{1'b0}};
          trig_s  = 1'b0;
        end
      endcase
    end
  end

  // Sequencer state, counters and registered trigger.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= SEARCH;
      stage_r     <= {SW{1'b0}};
      trig_r      <= 1'b0;
      fc_r        <= 16'h0000;
      win_cnt_r   <= {WIN_W{1'b0}};
      pulse_cnt_r <= {PW{1'b0}};
    end else begin
      state_r     <= state_s;
      stage_r     <= stage_s;
      trig_r      <= trig_s;
      fc_r        <= fc_s;
      win_cnt_r   <= win_cnt_s;
      pulse_cnt_r <= pulse_cnt_s;
    end
  end

  // Rotator runs on every cycle that trig is high.
  trig_activity_rotator #(
    .ROT_W    (ROT_W),
    .ROT_INIT (ROT_INIT)
  ) u_rotator (
    .clk    (clk),
    .rst    (rst),
    .reload (rot_reload_s),
    .en     (trig_r),
    .q      (rot_reg)
  );

  assign trig       = trig_r;
  assign stage      = stage_r;
  assign fire_count = fc_r;

endmodule

// File: tb/tb_seq_trigger_monitor.sv
// -----------------------------------------------------------------------------
// tb_seq_trigger_monitor
// Directed bench for seq_trigger_monitor. Two instances share the stimulus:
//   u_a : defaults (mismatch keeps progress, no window, sticky)
//   u_b : mismatch drops progress, WINDOW=5, pulsed with PULSE_LEN=3
// -----------------------------------------------------------------------------
module tb_seq_trigger_monitor;

  localparam logic [127:0] P0   = 128'h3243f6a8_885a308d_313198a2_e0370734;
  localparam logic [127:0] P1   = 128'h00112233_44556677_8899aabb_ccddeeff;
  localparam logic [127:0] P2   = 128'h0;
  localparam logic [127:0] P3   = 128'h1;
  localparam logic [127:0] DEAD = 128'hdeadbeef;
  localparam logic [127:0] RINI = {64{2'b10}};
  localparam logic [127:0] ROT1 = {64{2'b01}};

  logic         clk;
  logic         rst;
  logic         arm;
  logic         clear;
  logic         data_valid;
  logic [127:0] data;

  logic         trig_a, trig_b;
  logic [2:0]   stage_a, stage_b;
  logic [127:0] rot_a, rot_b;
  logic [15:0]  fc_a, fc_b;

  int errors = 0;
  int checks = 0;

  seq_trigger_monitor u_a (
    .clk        (clk),
    .rst        (rst),
    .arm        (arm),
    .clear      (clear),
    .data_valid (data_valid),
    .data       (data),
    .trig       (trig_a),
    .stage      (stage_a),
    .rot_reg    (rot_a),
    .fire_count (fc_a)
  );

  seq_trigger_monitor #(
    .RESET_ON_MISMATCH (1'b1),
    .WINDOW            (5),
    .STICKY            (1'b0),
    .PULSE_LEN         (3)
  ) u_b (
    .clk        (clk),
    .rst        (rst),
    .arm        (arm),
    .clear      (clear),
    .data_valid (data_valid),
    .data       (data),
    .trig       (trig_b),
    .stage      (stage_b),
    .rot_reg    (rot_b),
    .fire_count (fc_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of input, then sample just after the rising edge.
  task automatic cyc(input logic v, input logic [127:0] d);
    data_valid = v;
    data       = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst        = 1'b1;
    arm        = 1'b0;
    clear      = 1'b0;
    data_valid = 1'b0;
    data       = 128'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_trig_a", trig_a, 1'b0);
    chk("rst_stage_a", stage_a, 3'd0);
    chk("rst_rot_a", rot_a, RINI);
    chk("rst_fc_a", fc_a, 16'd0);
    chk("rst_trig_b", trig_b, 1'b0);
    rst = 1'b0;
    arm = 1'b1;

    // Full default sequence
    cyc(1'b1, P0);
    chk("seq1_stage_a", stage_a, 3'd1);
    chk("seq1_stage_b", stage_b, 3'd1);
    cyc(1'b1, P1);
    chk("seq2_stage_a", stage_a, 3'd2);
    cyc(1'b1, P2);
    chk("seq3_stage_a", stage_a, 3'd3);
    chk("seq3_trig_a", trig_a, 1'b0);
    cyc(1'b1, P3);
    chk("seq4_stage_a", stage_a, 3'd4);
    chk("seq4_trig_a", trig_a, 1'b1);
    chk("seq4_fc_a", fc_a, 16'd1);
    chk("seq4_trig_b", trig_b, 1'b1);
    chk("seq4_fc_b", fc_b, 16'd1);
    cyc(1'b0, 128'h0);
    chk("rot1_a", rot_a, ROT1);
    chk("pulse1_trig_b", trig_b, 1'b1);
    cyc(1'b0, 128'h0);
    chk("rot2_a", rot_a, RINI);
    chk("pulse2_trig_b", trig_b, 1'b1);
    cyc(1'b0, 128'h0);
    chk("pulse3_trig_b", trig_b, 1'b0);
    chk("pulse3_stage_b", stage_b, 3'd0);
    chk("pulse3_rot_b", rot_b, ROT1);
    chk("sticky_trig_a", trig_a, 1'b1);
    cyc(1'b0, 128'h0);
    chk("rot_hold_b", rot_b, ROT1);
    chk("rot4_a", rot_a, RINI);

    // Clear re-arms, keeps fire_count
    clear = 1'b1;
    cyc(1'b0, 128'h0);
    clear = 1'b0;
    chk("clr_trig_a", trig_a, 1'b0);
    chk("clr_stage_a", stage_a, 3'd0);
    chk("clr_rot_a", rot_a, RINI);
    chk("clr_fc_a", fc_a, 16'd1);
    chk("clr_rot_b", rot_b, RINI);

    // Second fire on both
    cyc(1'b1, P0);
    cyc(1'b1, P1);
    cyc(1'b1, P2);
    cyc(1'b1, P3);
    chk("fire2_fc_a", fc_a, 16'd2);
    chk("fire2_fc_b", fc_b, 16'd2);
    chk("fire2_trig_b", trig_b, 1'b1);
    clear = 1'b1;
    cyc(1'b0, 128'h0);
    clear = 1'b0;

    // Unrelated word after stage 2
    cyc(1'b1, P0);
    cyc(1'b1, P1);
    cyc(1'b1, DEAD);
    chk("mis_hold_a", stage_a, 3'd2);
    chk("mis_drop_b", stage_b, 3'd0);
    cyc(1'b1, P2);
    chk("mis_p2_a", stage_a, 3'd3);
    chk("mis_p2_b", stage_b, 3'd0);
    cyc(1'b1, P3);
    chk("mis_fire_a", trig_a, 1'b1);
    chk("mis_fc_a", fc_a, 16'd3);
    chk("mis_nofire_b", trig_b, 1'b0);
    chk("mis_fc_b", fc_b, 16'd2);
    clear = 1'b1;
    cyc(1'b0, 128'h0);
    clear = 1'b0;

    // Mismatching word equal to stage-0 pattern restarts at stage 1
    cyc(1'b1, P0);
    cyc(1'b1, P1);
    cyc(1'b1, P0);
    chk("restart_a", stage_a, 3'd2);
    chk("restart_b", stage_b, 3'd1);
    clear = 1'b1;
    cyc(1'b0, 128'h0);
    clear = 1'b0;

    // Window timeout
    cyc(1'b1, P0);
    repeat (4) cyc(1'b0, 128'h0);
    chk("win4_b", stage_b, 3'd1);
    cyc(1'b0, 128'h0);
    chk("win5_b", stage_b, 3'd0);
    chk("win5_a", stage_a, 3'd1);
    cyc(1'b1, P0);
    chk("win_rematch_b", stage_b, 3'd1);
    repeat (4) cyc(1'b0, 128'h0);
    cyc(1'b1, P1);
    chk("win_edge_b", stage_b, 3'd2);
    chk("win_edge_a", stage_a, 3'd2);
    clear = 1'b1;
    cyc(1'b0, 128'h0);
    clear = 1'b0;

    // Invalid matching data does not advance
    cyc(1'b0, P0);
    chk("novalid_a", stage_a, 3'd0);
    chk("novalid_b", stage_b, 3'd0);

    // arm low drops progress
    cyc(1'b1, P0);
    chk("arm_pre_a", stage_a, 3'd1);
    arm = 1'b0;
    cyc(1'b1, P1);
    chk("arm_low_a", stage_a, 3'd0);
    chk("arm_low_b", stage_b, 3'd0);
    arm = 1'b1;

    // Asynchronous reset at stage 3
    cyc(1'b1, P0);
    cyc(1'b1, P1);
    cyc(1'b1, P2);
    chk("pre_rst_a", stage_a, 3'd3);
    #2 rst = 1'b1;
    #1;
    chk("arst3_stage_a", stage_a, 3'd0);
    chk("arst3_stage_b", stage_b, 3'd0);
    #1 rst = 1'b0;

    // Asynchronous reset during FIRED
    cyc(1'b1, P0);
    cyc(1'b1, P1);
    cyc(1'b1, P2);
    cyc(1'b1, P3);
    chk("refire_trig_a", trig_a, 1'b1);
    chk("refire_fc_a", fc_a, 16'd1);
    cyc(1'b0, 128'h0);
    chk("refire_rot_a", rot_a, ROT1);
    #2 rst = 1'b1;
    #1;
    chk("arstf_trig_a", trig_a, 1'b0);
    chk("arstf_stage_a", stage_a, 3'd0);
    chk("arstf_rot_a", rot_a, RINI);
    chk("arstf_fc_a", fc_a, 16'd0);
    chk("arstf_trig_b", trig_b, 1'b0);
    #1 rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
